// File: rtl/irq_sample_rx.sv
// Toggle/sample link receiver: sync + edge detect, capture FIFO, link counters.
// Define IRQ_SAMPLE_RX_TSTAMP_EN to store a 32-bit cycle stamp with each sample.
module irq_sample_rx #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int EDGE_MODE = 1,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     irq_in,
  input  logic [DATA_W-1:0]        sample_in,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         edge_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic                     ovf_flag,
`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
  output logic [31:0]              m_tstamp,
`endif
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
  localparam int W = DATA_W + 32;
`else
  localparam int W = DATA_W;
`endif

  logic          s1, s2, s3;
  logic          rise, fall, ev;
  logic [W-1:0]  wdata;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  head;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] count;
  logic          full, do_pop, do_push, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign ev   = rise | ((EDGE_MODE != 0) & fall);

`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tstamp <= '0;
    else     tstamp <= tstamp + 32'd1;
  end

  assign wdata    = {tstamp, sample_in};
  assign m_tstamp = head[W-1:DATA_W];
`else
  assign wdata = sample_in;
`endif

  assign full    = (count == LW'(DEPTH));
  assign m_valid = (count != '0);
  assign do_pop  = m_valid & m_ready;
  assign do_push = ev & (~full | do_pop);
  assign drop    = ev & full & ~do_pop;
  assign rd_nxt  = rd_ptr + AW'(1);
  assign level   = count;
  assign m_data  = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // head is a register so m_data keeps its last value once the FIFO empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_pop) begin
        if (count > LW'(1)) head <= mem[rd_nxt];
        else if (do_push)   head <= wdata;
      end else if (!m_valid && do_push) begin
        head <= wdata;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (ev) edge_cnt <= edge_cnt + CNT_W'(1);
      if (clr_ovf) begin
        ovf_cnt  <= '0;
        ovf_flag <= 1'b0;
      end else if (drop) begin
        ovf_flag <= 1'b1;
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_irq_sample_rx.sv
// Scoreboard bench for irq_sample_rx: EDGE_MODE=1 main instance plus a
// rising-only instance sharing the same link stimulus.
module tb_irq_sample_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_in = 1'b0;
  logic [15:0] sample_in = 16'hFF55;
  logic        m_ready = 1'b1;
  logic        clr_ovf = 1'b0;

  logic [15:0] m_data;
  logic        m_valid;
  logic [4:0]  level;
  logic [15:0] edge_cnt, ovf_cnt;
  logic        ovf_flag;

  logic [15:0] m_data0;
  logic        m_valid0;
  logic        m_ready0 = 1'b1;
  logic [4:0]  level0;
  logic [15:0] edge_cnt0, ovf_cnt0;
  logic        ovf_flag0;

`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
  logic [31:0] m_tstamp, m_tstamp0;
`endif

  int checks = 0;
  int errors = 0;
  int beats0 = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  irq_sample_rx #(.DATA_W(16), .DEPTH(16), .EDGE_MODE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sample_in(sample_in),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .edge_cnt(edge_cnt), .ovf_cnt(ovf_cnt),
    .ovf_flag(ovf_flag),
`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
    .m_tstamp(m_tstamp),
`endif
    .clr_ovf(clr_ovf)
  );

  irq_sample_rx #(.DATA_W(16), .DEPTH(16), .EDGE_MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sample_in(sample_in),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
    .level(level0), .edge_cnt(edge_cnt0), .ovf_cnt(ovf_cnt0),
    .ovf_flag(ovf_flag0),
`ifdef IRQ_SAMPLE_RX_TSTAMP_EN
    .m_tstamp(m_tstamp0),
`endif
    .clr_ovf(clr_ovf)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every accepted beat must match the scoreboard head
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat unexpected got %h", m_data);
      end else begin
        check("beat", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
      end
    end
    if (!rst && m_valid0 && m_ready0) beats0++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [15:0] v);
    sample_in = v;
    tick(3);
    irq_in = ~irq_in;
    tick(5);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    tick(4);
    check("rst_valid", {31'h0, m_valid}, 0);
    check("rst_level", {27'h0, level}, 0);
    rst = 1'b0;
    tick(20);
    check("idle_valid", {31'h0, m_valid}, 0);
    check("idle_level", {27'h0, level}, 0);
    check("idle_edge", {16'h0, edge_cnt}, 0);
    check("idle_ovf_flag", {31'h0, ovf_flag}, 0);
    check("idle_ovf_cnt", {16'h0, ovf_cnt}, 0);
    check("idle_data", {16'h0, m_data}, 0);

    // latency: toggle before edge N, beat visible after edge N+2
    exp_q.push_back(16'hFF55);
    irq_in = 1'b1;
    tick(2);
    check("lat_rise_early", {31'h0, m_valid}, 0);
    tick(1);
    check("lat_rise", {31'h0, m_valid}, 1);
    tick(100);
    exp_q.push_back(16'hFF55);
    irq_in = 1'b0;
    tick(2);
    check("lat_fall_early", {31'h0, m_valid}, 0);
    tick(1);
    check("lat_fall", {31'h0, m_valid}, 1);
    wait_drain(50);
    tick(5);
    check("edge_both", {16'h0, edge_cnt}, 2);
    check("edge_rise_only", {16'h0, edge_cnt0}, 1);
    check("beats_rise_only", beats0, 1);

    // overflow: 18 samples into 16 entries with consumer stalled
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back(16'(i));
      toggle(16'(i));
    end
    check("ovf_level", {27'h0, level}, 16);
    check("ovf_cnt", {16'h0, ovf_cnt}, 2);
    check("ovf_flag", {31'h0, ovf_flag}, 1);
    check("ovf_head", {16'h0, m_data}, 0);
    check("ovf_edge", {16'h0, edge_cnt}, 20);
    check("ovf_edge0", {16'h0, edge_cnt0}, 10);
    check("ovf_beats0", beats0, 10);
    m_ready = 1'b1;
    wait_drain(100);
    check("drain_level", {27'h0, level}, 0);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    tick(1);
    check("clr_cnt", {16'h0, ovf_cnt}, 0);
    check("clr_flag", {31'h0, ovf_flag}, 0);

    // full, then push coinciding with a pop
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(16'h100 + 16'(i));
      toggle(16'h100 + 16'(i));
    end
    check("full_level", {27'h0, level}, 16);
    sample_in = 16'h01FF;
    exp_q.push_back(16'h01FF);
    tick(4);
    irq_in = ~irq_in;
    tick(2);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(3);
    check("fullpop_level", {27'h0, level}, 16);
    check("fullpop_ovf_cnt", {16'h0, ovf_cnt}, 0);
    check("fullpop_ovf_flag", {31'h0, ovf_flag}, 0);
    check("fullpop_edge", {16'h0, edge_cnt}, 37);
    check("fullpop_edge0", {16'h0, edge_cnt0}, 19);

    // partial drain to 5, then async reset mid-stream
    m_ready = 1'b1;
    tick(11);
    m_ready = 1'b0;
    check("part_level", {27'h0, level}, 5);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", {31'h0, m_valid}, 0);
    check("arst_level", {27'h0, level}, 0);
    exp_q.delete();
    sample_in = 16'hABCD;
    tick(3);
    rst = 1'b0;
    // irq_in is high at release, so one rising event is expected
    exp_q.push_back(16'hABCD);
    m_ready = 1'b1;
    wait_drain(50);
    tick(3);
    check("post_edge", {16'h0, edge_cnt}, 1);
    check("post_edge0", {16'h0, edge_cnt0}, 1);
    check("post_level", {27'h0, level}, 0);
    check("post_ovf_flag", {31'h0, ovf_flag}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sample_rx.md
Name: irq_sample_rx

Overview:
Receiving end of the interrupt-toggle/sample link driven by the test source block. Synchronises the asynchronous toggle line and detects its edges. On each qualifying edge, captures the accompanying parallel sample into a FIFO, which is drained by a valid/ready stream consumer (USB/DMA side). Keeps edge and overflow counters for link-health monitoring.

Parameters:
DATA_W, 16, sample width in bits.
DEPTH, 16, FIFO entries; power of two, >= 2.
EDGE_MODE, 1, 0 = rising edges only; 1 = both edges (matches a toggling source).
CNT_W, 16, width of edge_cnt and ovf_cnt.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
irq_in  in  1  toggle/interrupt line from source; asynchronous to clk
sample_in  in  DATA_W  sample from source; quasi-static, stable >= 4 clk around each irq_in edge
m_data  out  DATA_W  FIFO head sample
m_valid  out  1  head entry present
m_ready  in  1  consumer accepts head when m_valid & m_ready
level  out  $clog2(DEPTH)+1  current FIFO occupancy
edge_cnt  out  CNT_W  qualifying edges detected; wraps modulo 2^CNT_W
ovf_cnt  out  CNT_W  samples dropped on full; saturates at all-ones
ovf_flag  out  1  sticky; set on any drop
clr_ovf  in  1  synchronous pulse; clears ovf_flag and ovf_cnt

Behaviour:
- Reset (async assert, sync release by the rst source): sync chain = 0, edge-history reg = 0, FIFO empty. Outputs: m_valid=0, m_data=0, level=0, edge_cnt=0, ovf_cnt=0, ovf_flag=0.
- irq_in passes through a 2-FF synchroniser (s1, s2), then s2 is registered into s3.
- Edge detect: rise = s2 & ~s3; fall = ~s2 & s3.
  - EDGE_MODE=0: ev = rise.
  - EDGE_MODE=1: ev = rise | fall.
- Capture: in the cycle ev=1, sample_in is written into FIFO (push). Latency: irq_in change before clk edge N -> push at edge N+2 -> m_valid=1 and m_data valid after edge N+2.
- edge_cnt increments on every ev, regardless of FIFO state.
- FIFO: registered show-ahead; m_data = head whenever m_valid=1; m_data holds its last value when empty. Pop = m_valid & m_ready.
- Full (level==DEPTH) with push and no pop: sample dropped; ovf_flag<=1; ovf_cnt += 1 (saturating).
- Full with push and pop in the same cycle: both accepted; level unchanged; no drop.
- Empty with push: no same-cycle bypass; m_valid rises the following cycle.
- Pop while empty: ignored.
- clr_ovf in the same cycle as a drop: clear wins; ovf_cnt=0, ovf_flag=0.
- m_valid/m_data stable while m_valid & ~m_ready (AXI-stream rule).
- Reset mid-stream: all FIFO contents discarded; the first ev after release compares against s3=0. With irq_in high at release and EDGE_MODE=1, one rising ev is generated once the sync chain fills; this is intended.

Optional Feature:
IRQ_SAMPLE_RX_TSTAMP_EN
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps).
  - Its value in the ev cycle is stored alongside each sample in the FIFO (width DATA_W+32).
  - Adds port m_tstamp out 32, aligned with m_data; reset value 0.
- Undefined: no counter, no m_tstamp port, FIFO width DATA_W.

Test Plan:
- Reset hold, then release with irq_in=0, sample_in=16'hFF55, 20 clk idle -> m_valid=0, level=0, edge_cnt=0, ovf_flag=0.
- EDGE_MODE=1: toggle irq_in 0->1 then 1->0 (100 clk apart), m_ready=1 -> two beats of 16'hFF55; each m_valid asserts 3 clk after its edge; edge_cnt=2.
- EDGE_MODE=0: same stimulus -> one beat only; edge_cnt=1.
- m_ready=0, 18 toggles with sample_in = 0..17, DEPTH=16 -> level=16; ovf_cnt=2; ovf_flag=1; drain yields 0..15 in order; pulse clr_ovf -> ovf_cnt=0, ovf_flag=0.
- FIFO full with m_ready=1, toggle in the same cycle as a pop -> no drop; level stays 16; ovf_cnt unchanged.
- Assert rst with level=5 mid-drain -> m_valid=0 and level=0 immediately (async); with TSTAMP_EN, first post-reset beat has m_tstamp equal to the cycles from release to its ev.
